// File: rtl/demux_router_pkg.sv
// Shared constants for the demux_router slice: route-select polarity,
// per-slot state encoding, default widths and the slot-free helper.
package demux_router_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

  // Select polarity matches the team MUX: select high picks port 0.
  localparam logic PORT0_SEL = 1'b1;
  localparam logic PORT1_SEL = 1'b0;

  // One-entry slot state encoding.
  localparam logic [0:0] SLOT_EMPTY = 1'b0;
  localparam logic [0:0] SLOT_FULL  = 1'b1;

  // A slot can take a new word if it is empty or is being drained this cycle.
  function automatic logic slot_free(input logic valid, input logic ready);
    return !valid || ready;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output holding slot with valid/ready handshake.
// Optional saturating delivery counter when DEMUX_STATS_EN is defined.
module demux_out_slot
  import demux_router_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
`ifdef DEMUX_STATS_EN
  ,
  parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_free,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] o_cnt
`endif
);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic             w_drain;

  assign o_valid = (r_state == SLOT_FULL);
  assign o_data  = r_data;
  assign o_free  = slot_free(o_valid, i_ready);
  assign w_drain = o_valid && i_ready;

  // Slot state: load wins over drain, so drain+load keeps the slot FULL.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SLOT_EMPTY;
    end else if (i_load) begin
      r_state <= SLOT_FULL;
    end else if (w_drain) begin
      r_state <= SLOT_EMPTY;
    end
  end

  // Data register: captures the routed word on load, otherwise holds stable.
  // NOTE: this is a single register, not a memory, so it is reset to give a
  // defined all-zero output after reset rather than stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] r_cnt;

  assign o_cnt = r_cnt;

  // Delivery counter: counts output transfers, saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_drain && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/demux_router.sv
// Registered 1-to-2 demultiplexer: steers each accepted input word to
// output port 0 (in_sel=1) or port 1 (in_sel=0), each with a one-entry slot.
// Optional feature macro: DEMUX_STATS_EN adds per-port delivery counters.
module demux_router
  import demux_router_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  logic w_to_port0;
  logic w_free0;
  logic w_free1;
  logic w_accept;
  logic w_load0;
  logic w_load1;

  // Select decode and input handshake. in_ready depends only on the target
  // slot, so a stalled target blocks the input even if the other port is free.
  assign w_to_port0 = (in_sel == PORT0_SEL);
  assign in_ready   = w_to_port0 ? w_free0 : w_free1;
  assign w_accept   = in_valid && in_ready;
  assign w_load0    = w_accept && w_to_port0;
  assign w_load1    = w_accept && !w_to_port0;

  demux_out_slot #(
    .WIDTH (WIDTH)
`ifdef DEMUX_STATS_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) u_slot0 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load0),
    .i_data  (in_data),
    .o_free  (w_free0),
    .o_valid (out0_valid),
    .i_ready (out0_ready),
    .o_data  (out0_data)
`ifdef DEMUX_STATS_EN
    ,
    .o_cnt   (cnt0)
`endif
  );

  demux_out_slot #(
    .WIDTH (WIDTH)
`ifdef DEMUX_STATS_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) u_slot1 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load1),
    .i_data  (in_data),
    .o_free  (w_free1),
    .o_valid (out1_valid),
    .i_ready (out1_ready),
    .o_data  (out1_data)
`ifdef DEMUX_STATS_EN
    ,
    .o_cnt   (cnt1)
`endif
  );

endmodule

// File: tb/tb_demux_router.sv
// Scoreboard bench for demux_router: stimulus pushes expected words per port,
// a negedge monitor pops and compares on every output transfer.
module tb_demux_router;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
`endif

  demux_router #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef DEMUX_STATS_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_del0   = 0;
  int n_del1   = 0;

  logic [WIDTH-1:0] exp0[$];
  logic [WIDTH-1:0] exp1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a transfer seen at negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out0_valid && out0_ready) begin
        n_del0++;
        if (exp0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out0_spurious: got 0x%0h expected no word", out0_data);
        end else begin
          check("out0_data", out0_data, exp0.pop_front());
        end
      end
      if (out1_valid && out1_ready) begin
        n_del1++;
        if (exp1.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out1_spurious: got 0x%0h expected no word", out1_data);
        end else begin
          check("out1_data", out1_data, exp1.pop_front());
        end
      end
    end
  end

  // Producer-contract monitor: data/sel stable while stalled, sel never X.
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic             prev_sel;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (in_valid) begin
        check("in_sel_known", {63'd0, $isunknown(in_sel)}, 64'd0);
        if (prev_stall) begin
          check("stall_data_stable", in_data, prev_data);
          check("stall_sel_stable", in_sel, prev_sel);
        end
      end
      prev_stall = in_valid && !in_ready;
      prev_data  = in_data;
      prev_sel   = in_sel;
    end
  end

  // Present a word from posedge+1; wait (bounded) for in_ready; return posedge+1
  // after the accepting edge with in_valid still high.
  task automatic send(input logic [WIDTH-1:0] data, input logic sel, output int waits);
    bit ok;
    in_valid = 1'b1;
    in_data  = data;
    in_sel   = sel;
    waits    = 0;
    ok       = 1'b0;
    while (!ok && waits < 50) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else waits++;
    end
    if (!ok) begin
      check("send_timeout", 64'(waits), 64'd0);
      in_valid = 1'b0;
    end else begin
      if (sel) exp0.push_back(data);
      else exp1.push_back(data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int d0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_sel     = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    #1;
    // Reset state.
    check("rst_out0_valid", out0_valid, 0);
    check("rst_out1_valid", out1_valid, 0);
    check("rst_out0_data", out0_data, 0);
    check("rst_out1_data", out1_data, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef DEMUX_STATS_EN
    check("rst_cnt0", cnt0, 0);
    check("rst_cnt1", cnt1, 0);
`endif
    step(1);
    rst = 1'b0;

    // Reset then route.
    send(32'hA5A5_A5A5, 1'b1, w);
    check("route_a5_waits", 64'(w), 0);
    check("route_out0_valid", out0_valid, 1);
    check("route_out0_data", out0_data, 32'hA5A5_A5A5);
    send(32'h5A5A_5A5A, 1'b0, w);
    check("route_5a_waits", 64'(w), 0);
    check("route_out1_valid", out1_valid, 1);
    check("route_out1_data", out1_data, 32'h5A5A_5A5A);
    check("route_out0_drained", out0_valid, 0);
    idle();
    step(1);

    // Streaming throughput on port 0.
    d0 = n_del0;
    for (int i = 0; i < 8; i++) begin
      send(32'h0000_0100 + 32'(i), 1'b1, w);
      check("stream_waits", 64'(w), 0);
    end
    idle();
    step(1);
    check("stream_delivered", 64'(n_del0 - d0), 8);

    // Backpressure / head-of-line blocking on port 1.
    out1_ready = 1'b0;
    send(32'h11, 1'b0, w);
    check("hol_11_waits", 64'(w), 0);
    in_data = 32'h22;
    in_sel  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hol_in_ready", in_ready, 0);
      check("hol_out1_data", out1_data, 32'h11);
      check("hol_out1_valid", out1_valid, 1);
      check("hol_out0_valid", out0_valid, 0);
      @(posedge clk);
      #1;
    end
    out1_ready = 1'b1;
    send(32'h22, 1'b0, w);
    check("hol_22_waits", 64'(w), 0);
    check("hol_out1_22", out1_data, 32'h22);
    check("hol_out1_valid_22", out1_valid, 1);
    out1_ready = 1'b0;
    idle();

    // Independent drain: out1 stalled with 0x22, out0 drains 0x33.
    out0_ready = 1'b0;
    send(32'h33, 1'b1, w);
    idle();
    check("drain_out0_valid", out0_valid, 1);
    check("drain_out0_data", out0_data, 32'h33);
    out0_ready = 1'b1;
    step(1);
    check("drain_out0_cleared", out0_valid, 0);
    check("drain_out1_valid", out1_valid, 1);
    check("drain_out1_data", out1_data, 32'h22);

    // Reset mid-operation with both slots full.
    out0_ready = 1'b0;
    send(32'h44, 1'b1, w);
    idle();
    check("midrst_pre_out0", out0_valid, 1);
    check("midrst_pre_out1", out1_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out0_valid", out0_valid, 0);
    check("midrst_out1_valid", out1_valid, 0);
    check("midrst_out0_data", out0_data, 0);
    check("midrst_out1_data", out1_data, 0);
    exp0.delete();
    exp1.delete();
    #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    send(32'h55, 1'b0, w);
    check("midrst_55_waits", 64'(w), 0);
    check("midrst_out1_data", out1_data, 32'h55);
    check("midrst_out1_valid", out1_valid, 1);
    idle();
    step(2);

    // Counter run: fresh reset, 20 words on port 0 and 3 on port 1.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) send(32'h0000_0200 + 32'(i), 1'b1, w);
    for (int i = 0; i < 3; i++) send(32'h0000_0300 + 32'(i), 1'b0, w);
    idle();
    step(2);
`ifdef DEMUX_STATS_EN
    check("cnt0_saturated", cnt0, 15);
    check("cnt1_count", cnt1, 3);
`endif

    // End: everything expected was delivered.
    step(2);
    check("exp0_empty", 64'(exp0.size()), 0);
    check("exp1_empty", 64'(exp1.size()), 0);
    check("total_del0", 64'(n_del0), 30);
    check("total_del1", 64'(n_del1), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
